// File: rtl/link_sched.sv
// link_sched: phase scheduler monitoring the shared sen/sd link (optional LINK_SCHED_LEN_CHECK_EN enables frame length checking)
module link_sched #(
    parameter int DN_BITS   = 21,
    parameter int DN_FRAMES = 8,
    parameter int UP_BITS   = 13,
    parameter int UP_FRAMES = 18,
    parameter int GAP       = 2,
    parameter int TIMEOUT   = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       sen,
    input  logic       S1_done,
    input  logic       S2_done,
    output logic       updown,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code,
    output logic [4:0] frame_cnt
);
    typedef enum logic [2:0] {S_IDLE, S_DOWN, S_GAP, S_UP, S_DONE, S_ERR} state_t;
    state_t     state;
    logic [4:0] bitcnt;
    logic [3:0] gcnt;
    logic [7:0] tcnt;
    logic       low, fe, len_bad, extra, tout;
    logic [1:0] code;
    if (DN_FRAMES > 31 || UP_FRAMES > 31 || DN_BITS > 31 || UP_BITS > 31 ||
        GAP < 1 || GAP > 15 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_cfg
        $error("link_sched: parameter out of range");
    end
    assign low   = (sen == 1'b0);
    assign fe    = !low && bitcnt != 5'd0;
    assign extra = fe && frame_cnt == (state == S_UP ? 5'(UP_FRAMES) : 5'(DN_FRAMES));
    assign tout  = !low && tcnt == 8'(TIMEOUT - 1);
`ifdef LINK_SCHED_LEN_CHECK_EN
    assign len_bad = fe && bitcnt != (state == S_UP ? 5'(UP_BITS) : 5'(DN_BITS));
`else
    assign len_bad = 1'b0;
`endif
    assign code = len_bad ? 2'b10 : extra ? 2'b11 : 2'b01;
    // phase sequencing, frame/bit/timeout counting and sticky status flags
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            updown    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_code  <= 2'b00;
            frame_cnt <= 5'd0;
            bitcnt    <= 5'd0;
            gcnt      <= 4'd0;
            tcnt      <= 8'd0;
        end else begin
            case (state)
                S_DOWN, S_UP: begin
                    tcnt <= low ? 8'd0 : tcnt + 8'd1;
                    if (low) bitcnt <= bitcnt + {4'd0, bitcnt != 5'd31};
                    if (fe) begin
                        frame_cnt <= frame_cnt + 5'd1;
                        bitcnt    <= 5'd0;
                    end
                    if (len_bad || extra || tout) begin
                        state    <= S_ERR;
                        busy     <= 1'b0;
                        err      <= 1'b1;
                        err_code <= code;
                    end else if (state == S_DOWN && fe && frame_cnt + 5'd1 == 5'(DN_FRAMES)) begin
                        state <= S_GAP;
                        gcnt  <= 4'd0;
                    end else if (state == S_UP && frame_cnt == 5'(UP_FRAMES) && S1_done && S2_done) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                S_GAP: begin
                    tcnt <= low ? 8'd0 : tcnt + 8'd1;
                    if (low || tout) begin
                        state    <= S_ERR;
                        busy     <= 1'b0;
                        err      <= 1'b1;
                        err_code <= low ? 2'b11 : 2'b01;
                    end else if (gcnt == 4'(GAP)) begin
                        state     <= S_UP;
                        updown    <= 1'b1;
                        frame_cnt <= 5'd0;
                        bitcnt    <= 5'd0;
                    end else begin
                        gcnt <= gcnt + 4'd1;
                    end
                end
                default: begin
                    tcnt <= 8'd0;
                    if (start) begin
                        state     <= S_DOWN;
                        updown    <= 1'b0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        err       <= 1'b0;
                        err_code  <= 2'b00;
                        frame_cnt <= 5'd0;
                        bitcnt    <= 5'd0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_link_sched.sv
// tb_link_sched: directed table-driven and sequence checks for link_sched
module tb_link_sched;
    logic       clk = 1'b0, rst = 1'b0, start = 1'b0, sen = 1'b1, S1_done = 1'b0, S2_done = 1'b0;
    logic       updown, busy, done, err;
    logic [1:0] err_code;
    logic [4:0] frame_cnt;
    int tests = 0, fails = 0;

    typedef struct {
        string nm;
        logic  r, st, s, d;
        int    n;
        logic  ud, b, dn, e;
        logic [1:0] c;
        logic [4:0] f;
    } vec_t;
    vec_t tv[10];

    link_sched dut (
        .clk(clk), .rst(rst), .start(start), .sen(sen), .S1_done(S1_done), .S2_done(S2_done),
        .updown(updown), .busy(busy), .done(done), .err(err), .err_code(err_code), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic frame(input int n);
        sen = 1'b0;
        tick(n);
        sen = 1'b1;
        tick(1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic to_up();
        pulse_start();
        repeat (8) frame(21);
        tick(3);
    endtask

    task automatic chk_all(input string nm, input logic ud, b, dn, e, input logic [1:0] c, input logic [4:0] f);
        chk({nm, ".updown"}, updown, ud);
        chk({nm, ".busy"}, busy, b);
        chk({nm, ".done"}, done, dn);
        chk({nm, ".err"}, err, e);
        chk({nm, ".err_code"}, err_code, c);
        chk({nm, ".frame_cnt"}, frame_cnt, f);
    endtask

    initial begin
        tv[0] = '{"reset",      1, 0, 1, 0,   1, 0, 0, 0, 0, 2'b00, 5'd0};
        tv[1] = '{"start",      0, 1, 1, 0,   1, 0, 1, 0, 0, 2'b00, 5'd0};
        tv[2] = '{"dn_bits",    0, 0, 0, 0,  21, 0, 1, 0, 0, 2'b00, 5'd0};
        tv[3] = '{"dn_fend",    0, 0, 1, 0,   1, 0, 1, 0, 0, 2'b00, 5'd1};
        tv[4] = '{"to_254",     0, 0, 1, 0, 253, 0, 1, 0, 0, 2'b00, 5'd1};
        tv[5] = '{"to_255",     0, 0, 1, 0,   1, 0, 0, 0, 1, 2'b01, 5'd1};
        tv[6] = '{"restart",    0, 1, 1, 0,   1, 0, 1, 0, 0, 2'b00, 5'd0};
        tv[7] = '{"idle_253",   0, 0, 1, 0, 253, 0, 1, 0, 0, 2'b00, 5'd0};
        tv[8] = '{"idle_254",   0, 0, 1, 0,   1, 0, 1, 0, 0, 2'b00, 5'd0};
        tv[9] = '{"timeout",    0, 0, 1, 0,   1, 0, 0, 0, 1, 2'b01, 5'd0};
        #2;
        for (int i = 0; i < 10; i++) begin
            rst = tv[i].r; start = tv[i].st; sen = tv[i].s; S1_done = tv[i].d; S2_done = tv[i].d;
            tick(tv[i].n);
            chk_all(tv[i].nm, tv[i].ud, tv[i].b, tv[i].dn, tv[i].e, tv[i].c, tv[i].f);
        end
        rst = 1'b0; start = 1'b0; sen = 1'b1;

        // nominal session with an ignored start pulse during upload
        pulse_start();
        for (int k = 1; k <= 8; k++) begin
            frame(21);
            chk($sformatf("dn_frame%0d", k), frame_cnt, k);
        end
        tick(2);
        chk("gap_updown_low", updown, 0);
        tick(1);
        chk_all("gap_updown_high", 1, 1, 0, 0, 2'b00, 5'd0);
        repeat (5) frame(13);
        pulse_start();
        chk_all("start_in_up", 1, 1, 0, 0, 2'b00, 5'd5);
        repeat (13) frame(13);
        chk_all("up_18", 1, 1, 0, 0, 2'b00, 5'd18);
        S1_done = 1'b1;
        tick(1);
        chk("s1_only", done, 0);
        S2_done = 1'b1;
        tick(1);
        chk_all("done", 1, 0, 1, 0, 2'b00, 5'd18);
        S1_done = 1'b0; S2_done = 1'b0;
        tick(2);
        chk("done_sticky", done, 1);
        pulse_start();
        chk_all("restart_done", 0, 1, 0, 0, 2'b00, 5'd0);

        // extra upload frame
        rst = 1'b1; tick(1); rst = 1'b0;
        to_up();
        repeat (18) frame(13);
        frame(13);
        chk("extra.err", err, 1);
        chk("extra.code", err_code, 2'b11);
        chk("extra.busy", busy, 0);
        chk("extra.updown", updown, 1);

        // sen low during gap
        pulse_start();
        repeat (8) frame(21);
        sen = 1'b0;
        tick(1);
        sen = 1'b1;
        chk_all("gap_low", 0, 0, 0, 1, 2'b11, 5'd8);

        // short third download frame
        pulse_start();
        frame(21);
        frame(21);
        frame(20);
`ifdef LINK_SCHED_LEN_CHECK_EN
        chk_all("len_err", 0, 0, 0, 1, 2'b10, 5'd3);
`else
        chk_all("len_ignored", 0, 1, 0, 0, 2'b00, 5'd3);
`endif

        // asynchronous reset mid upload
        rst = 1'b1; tick(1); rst = 1'b0;
        to_up();
        repeat (5) frame(13);
        sen = 1'b0;
        tick(4);
        #2 rst = 1'b1;
        #1;
        chk_all("async_rst", 0, 0, 0, 0, 2'b00, 5'd0);
        #1 rst = 1'b0;
        sen = 1'b1;
        tick(1);
        chk("idle_after_rst", busy, 0);
        pulse_start();
        chk_all("start_after_rst", 0, 1, 0, 0, 2'b00, 5'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
